ps2_kbd_ctrl: RTL
=================

# ps2_kbd_ctrl

Keyboard controller that sequences the byte stream from `ps2_decoder` into complete key events and presents them to the 68k bus. Tracks the PS/2 set-2 prefix bytes (E0 extended, F0 break) and collapses each make/break sequence into one 10-bit event. Events are buffered in a small FIFO with overflow and error reporting, and a maskable interrupt. Sits between `ps2_decoder` (`valid`/`data`/`int_clear`) and the CPU register decode.

## Interface
- `FIFO_DEPTH`, 8: event FIFO entries. Power of two, 2..16.
- `PREFIX_TIMEOUT`, 250_000: clk cycles (10 ms at 25 MHz) a pending prefix may wait for its next byte.
- `clk`  in  1: system clock, 25 MHz.
- `reset`  in  1: reset is synchronous and active-high.
- `rx_valid`  in  1: one-cycle pulse from the decoder `valid`; `rx_data` is valid in that cycle.
- `rx_data`  in  8: received scan byte.
- `rx_int_clear`  out  1: one-cycle pulse to the decoder `int_clear`, issued after each accepted byte.
- `cpu_sel`  in  1: register access strobe, one cycle per access.
- `cpu_rd`  in  1: read qualifier.
- `cpu_wr`  in  1: write qualifier.
- `cpu_addr`  in  1: 0 = DATA, 1 = STATUS/CONTROL.
- `cpu_wdata`  in  16: write data.
- `cpu_rdata`  out  16: registered read data.
- `irq`  out  1: level interrupt to the CPU.

## Operation
- Event format, 10 bits: [9] break, [8] extended, [7:0] code.
- Prefix FSM states and transitions:
  - IDLE: E0 goes to EXT. F0 goes to BRK. Any other byte pushes {0,0,b}; state stays IDLE.
  - EXT: F0 goes to EXT_BRK. E0 stays in EXT. Any other byte pushes {0,1,b} and goes to IDLE.
  - BRK: E0 discards the break and goes to EXT. F0 stays in BRK. Any other byte pushes {1,0,b} and goes to IDLE.
  - EXT_BRK: E0 goes to EXT. F0 stays in EXT_BRK. Any other byte pushes {1,1,b} and goes to IDLE.
- 0x00 and 0xFF are keyboard error/overrun codes:
  - In any state they set sticky `kbd_err`, push nothing and force IDLE.
- E1 (Pause prefix) is not special: it pushes {0,0,E1} like any plain byte.
- Prefix timeout:
  - A counter clears on every accepted byte and counts while state ≠ IDLE.
  - At `PREFIX_TIMEOUT-1` the FSM returns to IDLE and nothing is pushed.
- Push into a full FIFO: the event is dropped and sticky `overflow` is set.
- DATA read (addr 0):
  - Returns [15] = 1 if the FIFO was non-empty, [9:0] = head event, other bits 0. The head entry is popped.
  - When the FIFO is empty, returns 0 and pops nothing.
- STATUS read (addr 1): [7] irq_en, [6] overflow, [5] kbd_err, [4] empty, [3:0] count (saturates at 15). Other bits 0.
- CONTROL write (addr 1):
  - [7] sets irq_en.
  - [6] = 1 clears overflow; [5] = 1 clears kbd_err.
  - [0] = 1 flushes the FIFO, forces the FSM to IDLE and clears the timeout counter.
- Writes to addr 0 are ignored. `cpu_rd` and `cpu_wr` asserted together: the read is performed and the write is ignored.
- `irq` = irq_en & (!empty | overflow | kbd_err), registered.

## Timing
- Reset values: all outputs 0, irq_en 0, flags 0, FIFO empty, FSM IDLE.
- `rx_valid` sampled at edge N:
  - FSM and FIFO update at N.
  - `rx_int_clear` is high for the cycle after N.
  - `irq` rises at N+1.
- Read strobe at edge N: `cpu_rdata` is valid after N and holds until the next read. A pop is visible in STATUS from the next access.
- Push and pop in the same cycle: both happen and count is unchanged. This is allowed when full: the pop frees a slot, so there is no overflow.
- Flush in the same cycle as `rx_valid`: flush wins and the byte is discarded. `rx_int_clear` still pulses.
- Reset mid-sequence drops any pending prefix. Reset overrides all other inputs.
- Pointers wrap modulo `FIFO_DEPTH`. Count width is log2(FIFO_DEPTH)+1 bits.

## Structure
- Package `ps2_kbd_pkg` holds:
  - FSM state encoding (IDLE, EXT, BRK, EXT_BRK);
  - byte constants (E0, F0, 00, FF);
  - register addresses and STATUS/CONTROL bit positions;
  - event field positions.
- Sub-module `ps2_event_fifo`: synchronous FIFO, width 10, depth `FIFO_DEPTH`, with push/pop/flush/full/empty/count.
- FSM, timeout counter, register file and irq logic sit in the top level.

## Test plan
- Stream 1C; F0 1C; E0 75; E0 F0 75, then four DATA reads:
  - reads return 0x801C, 0x821C, 0x8175, 0x8375;
  - a fifth read returns 0x0000.
- Push 9 plain bytes with FIFO_DEPTH = 8, read STATUS:
  - STATUS = 0x0048 (overflow, count 8);
  - `irq` = 1 with irq_en = 1;
  - writing 0x0040 clears overflow.
- Send E0, idle `PREFIX_TIMEOUT` cycles, send 1C:
  - the event is 0x001C (not extended);
  - an E0/F0 interleave (F0 E0 5A) yields 0x015A.
- Send FF:
  - STATUS bit 5 = 1, count 0, `irq` = 1 when enabled;
  - writing 0x0020 clears kbd_err.
- Full FIFO, then a DATA read in the same cycle as `rx_valid`: count stays 8 and overflow is not set.
- Assert reset mid-sequence (after F0), then send 1C: event 0x001C. Separately, a flush coinciding with `rx_valid` leaves count 0.

Source files
------------

// File: rtl/ps2_kbd_pkg.sv
// Shared definitions for the PS/2 keyboard controller: prefix FSM encoding,
// special scan bytes, register map and key-event field layout.
package ps2_kbd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } prefix_state_t;

   // Scan bytes with special meaning in set 2
   localparam logic [7:0] BYTE_EXT  = 8'hE0;
   localparam logic [7:0] BYTE_BRK  = 8'hF0;
   localparam logic [7:0] BYTE_ERR0 = 8'h00;
   localparam logic [7:0] BYTE_ERRF = 8'hFF;

   // Register map
   localparam logic ADDR_DATA   = 1'b0;
   localparam logic ADDR_STATUS = 1'b1;

   localparam int DATA_VALID_BIT  = 15;
   localparam int STAT_IRQ_EN_BIT = 7;
   localparam int STAT_OVF_BIT    = 6;
   localparam int STAT_ERR_BIT    = 5;
   localparam int STAT_EMPTY_BIT  = 4;
   localparam int CTRL_FLUSH_BIT  = 0;

   // Key event layout
   localparam int EV_WIDTH   = 10;
   localparam int EV_BRK_BIT = 9;
   localparam int EV_EXT_BIT = 8;

   function automatic logic [EV_WIDTH-1:0] make_event(input logic brk, input logic ext,
                                                      input logic [7:0] code);
      return {brk, ext, code};
   endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Small synchronous FIFO holding decoded key events. A pop frees a slot in the
// same cycle, so push+pop on a full FIFO is accepted. Flush overrides both.
module ps2_event_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 10,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign count   = count_reg;
   assign head    = mem[rd_ptr_reg];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Storage write; no reset needed since occupancy is tracked by count_reg
   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         if (do_push && !do_pop) begin
            count_reg <= count_reg + 1'b1;
         end else if (do_pop && !do_push) begin
            count_reg <= count_reg - 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: folds E0/F0 prefixes into 10-bit key events,
// queues them, and exposes DATA and STATUS/CONTROL registers plus an irq.
module ps2_kbd_ctrl
   import ps2_kbd_pkg::*;
#(
   parameter int FIFO_DEPTH     = 8,
   parameter int PREFIX_TIMEOUT = 250_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_int_clear,
   input  logic        cpu_sel,
   input  logic        cpu_rd,
   input  logic        cpu_wr,
   input  logic        cpu_addr,
   input  logic [15:0] cpu_wdata,
   output logic [15:0] cpu_rdata,
   output logic        irq
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int TW = $clog2(PREFIX_TIMEOUT);

   prefix_state_t        state_reg, state_next;
   logic [TW-1:0]        tmo_cnt_reg;
   logic                 timeout;
   logic                 ev_push;
   logic [EV_WIDTH-1:0]  ev_data;
   logic                 err_set;
   logic                 ovf_set;
   logic                 irq_en_reg, ovf_reg, err_reg;
   logic                 rx_int_clear_reg, irq_reg;
   logic [15:0]          cpu_rdata_reg;
   logic [EV_WIDTH-1:0]  fifo_head;
   logic                 fifo_full, fifo_empty;
   logic [CW-1:0]        fifo_count;
   logic [4:0]           count_wide;
   logic [3:0]           count_sat;
   logic                 data_rd, stat_rd, ctrl_wr, flush;
   logic                 unused_wdata;

   // Register decode: a simultaneous read and write performs only the read
   assign data_rd = cpu_sel && cpu_rd && (cpu_addr == ADDR_DATA);
   assign stat_rd = cpu_sel && cpu_rd && (cpu_addr == ADDR_STATUS);
   assign ctrl_wr = cpu_sel && cpu_wr && !cpu_rd && (cpu_addr == ADDR_STATUS);
   assign flush   = ctrl_wr && cpu_wdata[CTRL_FLUSH_BIT];
   assign unused_wdata = &{1'b0, cpu_wdata[15:8], cpu_wdata[4:1]};

   assign timeout    = (state_reg != ST_IDLE) && (tmo_cnt_reg == TW'(PREFIX_TIMEOUT - 1));
   assign ovf_set    = ev_push && fifo_full && !data_rd;
   assign count_wide = 5'(fifo_count);
   assign count_sat  = (count_wide > 5'd15) ? 4'hF : count_wide[3:0];

   ps2_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EV_WIDTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (ev_push),
      .push_data (ev_data),
      .pop       (data_rd),
      .flush     (flush),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Prefix FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Prefix FSM next state and event generation; flush discards the byte
   always_comb begin
      state_next = state_reg;
      ev_push    = 1'b0;
      ev_data    = '0;
      err_set    = 1'b0;
      if (flush) begin
         state_next = ST_IDLE;
      end else if (rx_valid) begin
         if (rx_data == BYTE_ERR0 || rx_data == BYTE_ERRF) begin
            err_set    = 1'b1;
            state_next = ST_IDLE;
         end else if (rx_data == BYTE_EXT) begin
            // A pending break is discarded when a new extended prefix arrives
            state_next = ST_EXT;
         end else if (rx_data == BYTE_BRK) begin
            case (state_reg)
               ST_IDLE:  state_next = ST_BRK;
               ST_EXT:   state_next = ST_EXT_BRK;
               default:  state_next = state_reg;
            endcase
         end else begin
            ev_push    = 1'b1;
            ev_data    = make_event((state_reg == ST_BRK) || (state_reg == ST_EXT_BRK),
                                    (state_reg == ST_EXT) || (state_reg == ST_EXT_BRK),
                                    rx_data);
            state_next = ST_IDLE;
         end
      end else if (timeout) begin
         state_next = ST_IDLE;
      end
   end

   // Prefix timeout counter: restarts on each byte, runs only with a prefix pending
   always_ff @(posedge clk) begin
      if (reset || flush || rx_valid || timeout || state_reg == ST_IDLE) begin
         tmo_cnt_reg <= '0;
      end else begin
         tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      end
   end

   // Sticky flags and interrupt enable; a new event outranks a same-cycle clear
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_en_reg <= 1'b0;
         ovf_reg    <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            irq_en_reg <= cpu_wdata[STAT_IRQ_EN_BIT];
         end
         if (ovf_set) begin
            ovf_reg <= 1'b1;
         end else if (ctrl_wr && cpu_wdata[STAT_OVF_BIT]) begin
            ovf_reg <= 1'b0;
         end
         if (err_set) begin
            err_reg <= 1'b1;
         end else if (ctrl_wr && cpu_wdata[STAT_ERR_BIT]) begin
            err_reg <= 1'b0;
         end
      end
   end

   // Registered read data, decoder acknowledge and interrupt level
   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_rdata_reg    <= '0;
         rx_int_clear_reg <= 1'b0;
         irq_reg          <= 1'b0;
      end else begin
         rx_int_clear_reg <= rx_valid;
         irq_reg          <= irq_en_reg && (!fifo_empty || ovf_reg || err_reg);
         if (data_rd) begin
            cpu_rdata_reg <= fifo_empty ? 16'h0000 : {1'b1, 5'b0, fifo_head};
         end else if (stat_rd) begin
            cpu_rdata_reg <= {8'h00, irq_en_reg, ovf_reg, err_reg, fifo_empty, count_sat};
         end
      end
   end

   assign rx_int_clear = rx_int_clear_reg;
   assign cpu_rdata    = cpu_rdata_reg;
   assign irq          = irq_reg;

endmodule
